genpad_poll_scheduler: RTL and testbench
========================================

# genpad_poll_scheduler

Frame-synchronous poll sequencer for two Genesis DB9 gamepad ports. On each poll request it drives the per-port select (TH) line through the 8-phase Genesis read sequence, one port after the other. It samples the six pad pins once per phase after a settling delay, classifies each pad as Master System, 3-button or 6-button, and commits both decoded words atomically with a done strobe. It sits between the board pad pins and the Genesis core's controller inputs.

## Interface
- PHASE_TICKS, 1000: cycles per select phase (20 µs at 50 MHz); must be > READ_LATENCY.
- READ_LATENCY, 48: phase-local count at which pins are sampled.
- GAP_TICKS, 500: idle cycles (select high) between port 0 and port 1 sequences; ≥1.
- iCLK  in  1  50 MHz system clock.
- iN_RESET  in  1  reset, asynchronous, active-low.
- iPOLL_REQ  in  1  single-cycle poll request (VBLANK start).
- iPORT_EN  in  2  per-port enable; disabled port skipped.
- iGENPAD0, iGENPAD1  in  6  pins {C/Start,B/A,Up/Z,Down/Y,Left/X,Right/Mode}, active-low.
- oGENPAD_SELECT  out  2  TH per port; idle high.
- oGENPAD_DECODED0, oGENPAD_DECODED1  out  12  {Z,Y,X,M,S,C,B,A,U,D,L,R}, active-high.
- oGENPAD_TYPE0, oGENPAD_TYPE1  out  2  0 MS/unknown, 1 3-button, 2 6-button, 3 inconsistent.
- oBUSY  out  1  sequence in progress.
- oPOLL_DONE  out  1  one-cycle strobe on commit.

## Operation
- FSM: IDLE → PHASE (port p, phase 0..7) → GAP (only between two enabled ports) → COMMIT → IDLE.
- IDLE accepts iPOLL_REQ if at least one port is enabled. Neither enabled: COMMIT directly; outputs unchanged; oPOLL_DONE still pulses.
- Select pattern per phase k=0..7: high when k even, low when k odd. Only the active port toggles; the other stays high.
- Sampling, p = pin word, per phase:
  - k0: C,B,U,D,L,R = ~p.
  - k1: p[1:0]==00 → 3-button; S,A = ~p[5:4]. Otherwise MS: decoded = {6'b0, C,B from k0, 2'b0, U,D,L,R from k0}.
  - k3: 3-button and p[1:0]!=00 → type 3.
  - k5: 3-button and p[3:0]==0000 → 6-button.
  - k6: 6-button only: Z,Y,X,M = ~p[3:0].
  - k7: no sample.
- Bits not produced by a type are zero.
- Per-port results accumulate in shadow registers. COMMIT copies both at once.
- Type 3: that port's decoded word is held at its previous value; the type output updates to 3.
- A disabled port commits decoded 0 and type 0.
- Request handling: an iPOLL_REQ while busy sets a single pending flag. Further requests while pending are dropped. Pending starts a new sequence the cycle after COMMIT.

## Timing
- Reset values: oGENPAD_SELECT=2'b11, decoded words 0, types 0, oBUSY 0, oPOLL_DONE 0, pending 0, FSM IDLE. Reset applies immediately (async).
- Request seen at edge t: phase 0 of first enabled port spans cycles t+1..t+P. Phase k spans t+1+kP..t+(k+1)P. The select change is registered at the first cycle of each phase.
- Sample cycle: phase-local counter == READ_LATENCY, counter starting at 0.
- Second port starts at t+1+8P+G. COMMIT and oPOLL_DONE occur at t+1+16P+G with both ports enabled, or t+1+8P with one.
- oBUSY is high from t+1 through the COMMIT cycle inclusive.
- Phase counter width is clog2(PHASE_TICKS). It wraps to 0 at PHASE_TICKS-1.
- iPORT_EN is sampled at request acceptance only. Mid-sequence changes are ignored.
- Reset mid-sequence: selects return high immediately, no commit, pending cleared.

## Structure
- Package genesis_pad_pkg:
  - type codes (MS, BTN3, BTN6, ERR);
  - decoded-bit index constants;
  - pin index constants;
  - select pattern constant 8'b01010101 (bit k = phase k level).
- Sub-module genpad_port_decoder: shadow registers and per-phase classification/sampling rules. The scheduler instantiates one, muxes the active port's pins into it, and saves each port's result into a per-port shadow register at the end of that port's sequence.

## Test plan
Use P=16, READ_LATENCY=4, G=8.
1. Reset → oGENPAD_SELECT=11, all decoded/type outputs 0, oBUSY=0; async reset assert mid-cycle clears immediately.
2. Port0 6-button model pressing A+Z, port1 3-button pressing Start+Up, request at t → DECODED0=12'h810, TYPE0=2, DECODED1=12'h088, TYPE1=1, oPOLL_DONE at t+265.
3. Port0 MS pad pressing button1 (B pin) and Right → DECODED0=12'h021, TYPE0=0.
4. Three requests: second during busy, third during pending → exactly two done strobes; the second sequence starts the cycle after the first COMMIT.
5. iPORT_EN=01 → oGENPAD_SELECT[1] constantly 1, DECODED1=0, done at t+129.
6. 3-button model reports L/R≠00 at phase 3 → TYPE0=3, DECODED0 retains prior value. Reset asserted during phase 3 of port 0 → no done, selects 11; a fresh request completes normally.

Source files
------------

// File: rtl/genesis_pad_pkg.sv
// Shared encodings for the Genesis DB9 pad poll scheduler: pad type codes,
// decoded-word / pin bit positions and the per-phase select (TH) pattern.
package genesis_pad_pkg;

  typedef enum logic [1:0] {
    PAD_MS   = 2'd0,
    PAD_BTN3 = 2'd1,
    PAD_BTN6 = 2'd2,
    PAD_ERR  = 2'd3
  } pad_type_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PHASE,
    S_GAP,
    S_COMMIT
  } sched_state_e;

  // Decoded word {Z,Y,X,M,S,C,B,A,U,D,L,R}, active-high
  localparam int unsigned DEC_R = 0;
  localparam int unsigned DEC_L = 1;
  localparam int unsigned DEC_D = 2;
  localparam int unsigned DEC_U = 3;
  localparam int unsigned DEC_A = 4;
  localparam int unsigned DEC_B = 5;
  localparam int unsigned DEC_C = 6;
  localparam int unsigned DEC_S = 7;
  localparam int unsigned DEC_M = 8;
  localparam int unsigned DEC_X = 9;
  localparam int unsigned DEC_Y = 10;
  localparam int unsigned DEC_Z = 11;

  // Pad pins {C/Start,B/A,Up/Z,Down/Y,Left/X,Right/Mode}, active-low
  localparam int unsigned PIN_RIGHT_MODE = 0;
  localparam int unsigned PIN_LEFT_X     = 1;
  localparam int unsigned PIN_DOWN_Y     = 2;
  localparam int unsigned PIN_UP_Z       = 3;
  localparam int unsigned PIN_B_A        = 4;
  localparam int unsigned PIN_C_START    = 5;

  // Bit k is the TH level driven during phase k
  localparam logic [7:0] SEL_PATTERN = 8'b0101_0101;

endpackage

// File: rtl/genpad_port_decoder.sv
// Per-phase sampling and pad classification for the port currently being
// sequenced; holds the in-progress decoded word and type.
module genpad_port_decoder
  import genesis_pad_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sample_i,
  input  logic [2:0]  phase_i,
  input  logic [5:0]  pins_i,
  output logic [11:0] decoded_o,
  output pad_type_e   type_o
);

  logic [11:0] dec_q, dec_d;
  pad_type_e   type_q, type_d;

  always_comb begin
    dec_d  = dec_q;
    type_d = type_q;
    if (sample_i) begin
      case (phase_i)
        // Phase 0 rewrites the whole word, so no separate clear is needed
        3'd0: begin
          dec_d        = '0;
          dec_d[DEC_C] = ~pins_i[PIN_C_START];
          dec_d[DEC_B] = ~pins_i[PIN_B_A];
          dec_d[DEC_U] = ~pins_i[PIN_UP_Z];
          dec_d[DEC_D] = ~pins_i[PIN_DOWN_Y];
          dec_d[DEC_L] = ~pins_i[PIN_LEFT_X];
          dec_d[DEC_R] = ~pins_i[PIN_RIGHT_MODE];
          type_d       = PAD_MS;
        end
        3'd1: begin
          if (!pins_i[PIN_LEFT_X] && !pins_i[PIN_RIGHT_MODE]) begin
            type_d       = PAD_BTN3;
            dec_d[DEC_S] = ~pins_i[PIN_C_START];
            dec_d[DEC_A] = ~pins_i[PIN_B_A];
          end
        end
        3'd3: begin
          if (type_q == PAD_BTN3 && (pins_i[PIN_LEFT_X] || pins_i[PIN_RIGHT_MODE]))
            type_d = PAD_ERR;
        end
        3'd5: begin
          if (type_q == PAD_BTN3 && pins_i[3:0] == 4'b0000)
            type_d = PAD_BTN6;
        end
        3'd6: begin
          if (type_q == PAD_BTN6) begin
            dec_d[DEC_Z] = ~pins_i[PIN_UP_Z];
            dec_d[DEC_Y] = ~pins_i[PIN_DOWN_Y];
            dec_d[DEC_X] = ~pins_i[PIN_LEFT_X];
            dec_d[DEC_M] = ~pins_i[PIN_RIGHT_MODE];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_q  <= '0;
      type_q <= PAD_MS;
    end else begin
      dec_q  <= dec_d;
      type_q <= type_d;
    end
  end

  assign decoded_o = dec_q;
  assign type_o    = type_q;

endmodule

// File: rtl/genpad_poll_scheduler.sv
// Frame-synchronous poll sequencer for two Genesis pad ports: walks TH through
// the 8-phase read per enabled port and commits both results atomically.
module genpad_poll_scheduler
  import genesis_pad_pkg::*;
#(
  parameter int unsigned PHASE_TICKS  = 1000,
  parameter int unsigned READ_LATENCY = 48,
  parameter int unsigned GAP_TICKS    = 500
) (
  input  logic        iCLK,
  input  logic        iN_RESET,
  input  logic        iPOLL_REQ,
  input  logic [1:0]  iPORT_EN,
  input  logic [5:0]  iGENPAD0,
  input  logic [5:0]  iGENPAD1,
  output logic [1:0]  oGENPAD_SELECT,
  output logic [11:0] oGENPAD_DECODED0,
  output logic [11:0] oGENPAD_DECODED1,
  output logic [1:0]  oGENPAD_TYPE0,
  output logic [1:0]  oGENPAD_TYPE1,
  output logic        oBUSY,
  output logic        oPOLL_DONE
);

  localparam int unsigned CW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam int unsigned GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_TICKS - 1);
  localparam logic [CW-1:0] READ_AT  = CW'(READ_LATENCY);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

  sched_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]    phase_q, phase_d;
  logic          port_q, port_d;
  logic [1:0]    en_q, en_d;
  logic          pend_q, pend_d;
  logic [1:0]    sel_q, sel_d;
  logic          commit_load;

  logic [11:0] sh_dec_q [2];
  logic [11:0] sh_dec_d [2];
  pad_type_e   sh_type_q [2];
  pad_type_e   sh_type_d [2];
  logic [11:0] out_dec_q [2];
  logic [11:0] out_dec_d [2];
  pad_type_e   out_type_q [2];
  pad_type_e   out_type_d [2];
  logic [11:0] src_dec [2];
  pad_type_e   src_type [2];

  logic [11:0] cur_dec;
  pad_type_e   cur_type;
  logic        sample;
  logic        seq_end;

  assign sample  = (state_q == S_PHASE) && (cnt_q == READ_AT);
  assign seq_end = (state_q == S_PHASE) && (cnt_q == CNT_LAST) && (phase_q == 3'd7);

  genpad_port_decoder u_decoder (
    .clk_i     (iCLK),
    .rst_ni    (iN_RESET),
    .sample_i  (sample),
    .phase_i   (phase_q),
    .pins_i    (port_q ? iGENPAD1 : iGENPAD0),
    .decoded_o (cur_dec),
    .type_o    (cur_type)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    phase_d     = phase_q;
    port_d      = port_q;
    en_d        = en_q;
    pend_d      = pend_q;
    commit_load = 1'b0;
    case (state_q)
      // A pending request launches straight out of COMMIT, no IDLE cycle
      S_IDLE, S_COMMIT: begin
        state_d = S_IDLE;
        if (iPOLL_REQ || pend_q) begin
          pend_d  = 1'b0;
          en_d    = iPORT_EN;
          cnt_d   = '0;
          phase_d = '0;
          port_d  = ~iPORT_EN[0];
          state_d = (iPORT_EN == 2'b00) ? S_COMMIT : S_PHASE;
        end
      end
      S_PHASE: begin
        if (iPOLL_REQ) pend_d = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          phase_d = phase_q + 3'd1;
          if (phase_q == 3'd7) begin
            if (!port_q && en_q[1]) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              state_d     = S_COMMIT;
              commit_load = 1'b1;
            end
          end
        end
      end
      S_GAP: begin
        if (iPOLL_REQ) pend_d = 1'b1;
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          state_d = S_PHASE;
          port_d  = 1'b1;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sel_d = '1;
    if (state_d == S_PHASE) sel_d[port_d] = SEL_PATTERN[phase_d];
  end

  // The finishing port's result is still in the decoder at commit time
  always_comb begin
    src_dec[0]  = port_q ? sh_dec_q[0]  : cur_dec;
    src_type[0] = port_q ? sh_type_q[0] : cur_type;
    src_dec[1]  = port_q ? cur_dec      : sh_dec_q[1];
    src_type[1] = port_q ? cur_type     : sh_type_q[1];
    for (int unsigned i = 0; i < 2; i++) begin
      sh_dec_d[i]   = sh_dec_q[i];
      sh_type_d[i]  = sh_type_q[i];
      out_dec_d[i]  = out_dec_q[i];
      out_type_d[i] = out_type_q[i];
      if (commit_load) begin
        if (!en_q[i]) begin
          out_dec_d[i]  = '0;
          out_type_d[i] = PAD_MS;
        end else if (src_type[i] == PAD_ERR) begin
          out_type_d[i] = PAD_ERR;
        end else begin
          out_dec_d[i]  = src_dec[i];
          out_type_d[i] = src_type[i];
        end
      end
    end
    if (seq_end) begin
      sh_dec_d[port_q]  = cur_dec;
      sh_type_d[port_q] = cur_type;
    end
  end

  always_ff @(posedge iCLK or negedge iN_RESET) begin
    if (!iN_RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      phase_q <= '0;
      port_q  <= 1'b0;
      en_q    <= '0;
      pend_q  <= 1'b0;
      sel_q   <= '1;
      for (int unsigned i = 0; i < 2; i++) begin
        sh_dec_q[i]   <= '0;
        sh_type_q[i]  <= PAD_MS;
        out_dec_q[i]  <= '0;
        out_type_q[i] <= PAD_MS;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      phase_q <= phase_d;
      port_q  <= port_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      for (int unsigned i = 0; i < 2; i++) begin
        sh_dec_q[i]   <= sh_dec_d[i];
        sh_type_q[i]  <= sh_type_d[i];
        out_dec_q[i]  <= out_dec_d[i];
        out_type_q[i] <= out_type_d[i];
      end
    end
  end

  assign oGENPAD_SELECT   = sel_q;
  assign oGENPAD_DECODED0 = out_dec_q[0];
  assign oGENPAD_DECODED1 = out_dec_q[1];
  assign oGENPAD_TYPE0    = out_type_q[0];
  assign oGENPAD_TYPE1    = out_type_q[1];
  assign oBUSY            = (state_q != S_IDLE);
  assign oPOLL_DONE       = (state_q == S_COMMIT);

endmodule

// File: tb/tb_genpad_poll_scheduler.sv
// Directed bench for genpad_poll_scheduler with behavioural MS / 3-button /
// 6-button pad models driven off each port's TH line.
module tb_genpad_poll_scheduler;

  localparam int P  = 16;
  localparam int RL = 4;
  localparam int G  = 8;

  localparam int K_MS  = 0;
  localparam int K_3B  = 1;
  localparam int K_6B  = 2;
  localparam int K_BAD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  en = 2'b00;
  logic [5:0]  pad0, pad1;
  logic [1:0]  sel;
  logic [11:0] dec0, dec1;
  logic [1:0]  typ0, typ1;
  logic        busy, done;

  int          kind0 = K_MS, kind1 = K_MS;
  logic [11:0] btn0 = '0, btn1 = '0;
  int          fcnt0 = 0, fcnt1 = 0;
  logic [1:0]  prev_sel = 2'b11;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  genpad_poll_scheduler #(
    .PHASE_TICKS  (P),
    .READ_LATENCY (RL),
    .GAP_TICKS    (G)
  ) dut (
    .iCLK             (clk),
    .iN_RESET         (rst_n),
    .iPOLL_REQ        (req),
    .iPORT_EN         (en),
    .iGENPAD0         (pad0),
    .iGENPAD1         (pad1),
    .oGENPAD_SELECT   (sel),
    .oGENPAD_DECODED0 (dec0),
    .oGENPAD_DECODED1 (dec1),
    .oGENPAD_TYPE0    (typ0),
    .oGENPAD_TYPE1    (typ1),
    .oBUSY            (busy),
    .oPOLL_DONE       (done)
  );

  // Pads count TH falling edges; the count restarts between sequences
  always @(negedge clk) begin
    if (!busy || done) begin
      fcnt0 <= 0;
      fcnt1 <= 0;
    end else begin
      if (prev_sel[0] && !sel[0]) fcnt0 <= fcnt0 + 1;
      if (prev_sel[1] && !sel[1]) fcnt1 <= fcnt1 + 1;
    end
    prev_sel <= sel;
  end

  // b uses decoded layout {Z,Y,X,M,S,C,B,A,U,D,L,R}; returns active-low pins
  function automatic logic [5:0] pad_pins(input int kind, input logic [11:0] b,
                                          input logic th, input int n);
    logic [5:0] p;
    if (kind == K_MS || th) begin
      if (kind == K_6B && th && n == 3) p = ~{b[6], b[5], b[11], b[10], b[9], b[8]};
      else                              p = ~{b[6], b[5], b[3], b[2], b[1], b[0]};
    end else begin
      p = {~b[7], ~b[4], ~b[3], ~b[2], 2'b00};
      if (kind == K_BAD && n == 2) p[1:0] = 2'b01;
      if (kind == K_6B && n == 3)  p[3:0] = 4'b0000;
      if (kind == K_6B && n >= 4)  p[3:0] = 4'b1111;
    end
    return p;
  endfunction

  always_comb begin
    pad0 = pad_pins(kind0, btn0, sel[0], fcnt0);
    pad1 = pad_pins(kind1, btn1, sel[1], fcnt1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Request sampled at edge t; lat counts edges from t to the first done cycle
  task automatic do_poll(input logic [1:0] e, output int lat,
                         output bit s0_hi, output bit s1_hi);
    int d;
    s0_hi = 1'b1;
    s1_hi = 1'b1;
    @(negedge clk);
    en  = e;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    d = 0;
    while (!done && d < 2000) begin
      if (!sel[0]) s0_hi = 1'b0;
      if (!sel[1]) s1_hi = 1'b0;
      @(negedge clk);
      d++;
    end
    lat = done ? d : -1;
  endtask

  typedef struct {
    logic [1:0]  en;
    int          k0;
    logic [11:0] b0;
    int          k1;
    logic [11:0] b1;
    logic [11:0] d0;
    logic [1:0]  t0;
    logic [11:0] d1;
    logic [1:0]  t1;
    int          lat;
  } vec_t;

  vec_t vt[7];

  initial begin
    int  lat;
    bit  s0, s1;
    int  d, ndone, first_at, second_at;
    logic busy_after;

    vt[0] = '{2'b11, K_6B,  12'h810, K_3B, 12'h088, 12'h810, 2'd2, 12'h088, 2'd1, 264};
    vt[1] = '{2'b01, K_MS,  12'h021, K_6B, 12'hFFF, 12'h021, 2'd0, 12'h000, 2'd0, 128};
    vt[2] = '{2'b10, K_6B,  12'hFFF, K_6B, 12'h340, 12'h000, 2'd0, 12'h340, 2'd2, 128};
    vt[3] = '{2'b11, K_6B,  12'hFFF, K_MS, 12'h000, 12'hFFF, 2'd2, 12'h000, 2'd0, 264};
    vt[4] = '{2'b11, K_BAD, 12'h008, K_3B, 12'h044, 12'hFFF, 2'd3, 12'h044, 2'd1, 264};
    vt[5] = '{2'b00, K_MS,  12'h000, K_MS, 12'h000, 12'hFFF, 2'd3, 12'h044, 2'd1, 0};
    vt[6] = '{2'b11, K_3B,  12'h000, K_MS, 12'h009, 12'h000, 2'd1, 12'h009, 2'd0, 264};

    #12;
    chk("rst_sel",  32'(sel),  32'h3);
    chk("rst_dec0", 32'(dec0), 32'h0);
    chk("rst_dec1", 32'(dec1), 32'h0);
    chk("rst_typ0", 32'(typ0), 32'h0);
    chk("rst_typ1", 32'(typ1), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      kind0 = vt[i].k0; btn0 = vt[i].b0;
      kind1 = vt[i].k1; btn1 = vt[i].b1;
      do_poll(vt[i].en, lat, s0, s1);
      chk($sformatf("v%0d_lat", i),  32'(lat),  32'(vt[i].lat));
      chk($sformatf("v%0d_dec0", i), 32'(dec0), 32'(vt[i].d0));
      chk($sformatf("v%0d_typ0", i), 32'(typ0), 32'(vt[i].t0));
      chk($sformatf("v%0d_dec1", i), 32'(dec1), 32'(vt[i].d1));
      chk($sformatf("v%0d_typ1", i), 32'(typ1), 32'(vt[i].t1));
      if (!vt[i].en[0]) chk($sformatf("v%0d_sel0_idle", i), 32'(s0), 32'h1);
      if (!vt[i].en[1]) chk($sformatf("v%0d_sel1_idle", i), 32'(s1), 32'h1);
    end

    // Pending: one request while busy is queued, one while pending is dropped
    kind0 = K_6B; btn0 = 12'h810;
    kind1 = K_3B; btn1 = 12'h088;
    @(negedge clk);
    en  = 2'b11;
    req = 1'b1;
    ndone = 0; first_at = -1; second_at = -1; busy_after = 1'b0;
    for (d = -1; d < 850; d++) begin
      @(negedge clk);
      req = (d + 1 == 10) || (d + 1 == 40);
      if (done) begin
        ndone++;
        if (ndone == 1) first_at = d + 1;
        if (ndone == 2) second_at = d + 1;
      end
      if (ndone == 1 && d == first_at) busy_after = busy;
    end
    chk("pend_ndone",     32'(ndone),      32'd2);
    chk("pend_first",     32'(first_at),   32'd264);
    chk("pend_second",    32'(second_at),  32'd529);
    chk("pend_busy_hold", 32'(busy_after), 32'h1);
    chk("pend_dec0",      32'(dec0),       32'h810);
    chk("pend_dec1",      32'(dec1),       32'h088);

    // Asynchronous reset during phase 3 of port 0
    @(negedge clk);
    en  = 2'b11;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (3 * P + 5) @(negedge clk);
    chk("midrst_sel_ph3", 32'(sel), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_sel",  32'(sel),  32'h3);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_dec0", 32'(dec0), 32'h0);
    chk("midrst_typ0", 32'(typ0), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    do_poll(2'b11, lat, s0, s1);
    chk("fresh_lat",  32'(lat),  32'd264);
    chk("fresh_dec0", 32'(dec0), 32'h810);
    chk("fresh_typ0", 32'(typ0), 32'h2);
    chk("fresh_dec1", 32'(dec1), 32'h088);
    chk("fresh_typ1", 32'(typ1), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
